// File: rtl/arbitro_pkg.sv
// Shared definitions for the round-robin timer arbiter: FSM encoding and
// the one-hot grant helper.
package arbitro_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int MAX_REQ = 8;

  // One-hot vector for a requester index; callers truncate to N_REQ bits.
  function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
    logic [MAX_REQ-1:0] v;
    v      = {MAX_REQ{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/arbitro_temporizador_if.sv
// Requester-side bus of the timer arbiter: requests and terminal counts in,
// grant/done/busy and counter observation out.
interface arbitro_temporizador_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4
);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] tc;
  logic [N_REQ-1:0]       grant;
  logic [N_REQ-1:0]       done;
  logic                   busy;
  logic [WIDTH-1:0]       cont;

  modport master (
    output req,
    output tc,
    input  grant,
    input  done,
    input  busy,
    input  cont
  );

  modport slave (
    input  req,
    input  tc,
    output grant,
    output done,
    output busy,
    output cont
  );

endinterface

// File: rtl/arbitro_temporizador_rr_sel.sv
// Round-robin winner search: first set request bit starting at ptr and
// wrapping modulo N_REQ.
module rr_sel #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] win,
  output logic             any_req
);

  int idx_s;

  // Scan from lowest priority to highest so the last hit is the winner.
  always_comb begin
    win     = {IDX_W{1'b0}};
    idx_s   = 0;
    any_req = |req;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx_s = (int'(ptr) + i) % N_REQ;
      win   = req[idx_s] ? IDX_W'(idx_s) : win;
    end
  end

endmodule

// File: rtl/arbitro_temporizador.sv
// Shares one terminal-count up-counter among N_REQ requesters: round-robin
// grant, counter load/run, and a single-cycle done pulse to the winner.
module arbitro_temporizador
  import arbitro_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  arbitro_temporizador_if.slave  bus
);

  localparam int IDX_W = $clog2(N_REQ);

  state_t           state_r, state_s;
  logic [N_REQ-1:0] grant_r, grant_s;
  logic [N_REQ-1:0] done_r,  done_s;
  logic             busy_r,  busy_s;
  logic [WIDTH-1:0] cont_r,  cont_s;
  logic [WIDTH-1:0] tc_lat_r, tc_lat_s;
  logic [IDX_W-1:0] ptr_r,   ptr_s;
  logic [IDX_W-1:0] win_r,   win_s;
  logic [IDX_W-1:0] sel_win_s;
  logic [IDX_W-1:0] ptr_nxt_s;
  logic             any_req_s;

  rr_sel #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_sel (
    .req     (bus.req),
    .ptr     (ptr_r),
    .win     (sel_win_s),
    .any_req (any_req_s)
  );

  assign ptr_nxt_s = (int'(win_r) == N_REQ - 1) ? {IDX_W{1'b0}}
                                                 : win_r + IDX_W'(1'b1);

  // Next-state and next-output logic; done defaults low so it pulses once.
  always_comb begin
    state_s  = state_r;
    grant_s  = grant_r;
    done_s   = {N_REQ{1'b0}};
    busy_s   = busy_r;
    cont_s   = cont_r;
    tc_lat_s = tc_lat_r;
    ptr_s    = ptr_r;
    win_s    = win_r;
    case (state_r)
      S_IDLE: begin
        if (any_req_s) begin
          state_s  = S_COUNT;
          win_s    = sel_win_s;
          grant_s  = N_REQ'(onehot(3'(sel_win_s)));
          tc_lat_s = bus.tc[int'(sel_win_s)*WIDTH +: WIDTH];
          cont_s   = {WIDTH{1'b0}};
          busy_s   = 1'b1;
        end else begin
          state_s  = S_IDLE;
        end
      end
      S_COUNT: begin
        if (!bus.req[win_r]) begin
          state_s = S_IDLE;
          grant_s = {N_REQ{1'b0}};
          busy_s  = 1'b0;
          cont_s  = {WIDTH{1'b0}};
          ptr_s   = ptr_nxt_s;
        end else if (cont_r == tc_lat_r) begin
          state_s = S_DONE;
          done_s  = grant_r;
        end else begin
          cont_s  = cont_r + WIDTH'(1'b1);
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
        grant_s = {N_REQ{1'b0}};
        busy_s  = 1'b0;
        cont_s  = {WIDTH{1'b0}};
        ptr_s   = ptr_nxt_s;
      end
      default: begin
        state_s = S_IDLE;
        grant_s = {N_REQ{1'b0}};
        busy_s  = 1'b0;
        cont_s  = {WIDTH{1'b0}};
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= S_IDLE;
      grant_r  <= {N_REQ{1'b0}};
      done_r   <= {N_REQ{1'b0}};
      busy_r   <= 1'b0;
      cont_r   <= {WIDTH{1'b0}};
      tc_lat_r <= {WIDTH{1'b0}};
      ptr_r    <= {IDX_W{1'b0}};
      win_r    <= {IDX_W{1'b0}};
    end else begin
      state_r  <= state_s;
      grant_r  <= grant_s;
      done_r   <= done_s;
      busy_r   <= busy_s;
      cont_r   <= cont_s;
      tc_lat_r <= tc_lat_s;
      ptr_r    <= ptr_s;
      win_r    <= win_s;
    end
  end

  assign bus.grant = grant_r;
  assign bus.done  = done_r;
  assign bus.busy  = busy_r;
  assign bus.cont  = cont_r;

endmodule
